// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out serializer.
//   state_t     : FSM state encoding (IDLE, SHIFT, GAP)
//   GAP_CNT_W   : width of the inter-word gap counter (gap up to 255 cycles)
//   bit_cnt_w() : bit-counter width for a given word width, $clog2(WIDTH)
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int GAP_CNT_W = 8;

  // Never narrower than one bit, so a 2-bit word still gets a counter.
  function automatic int bit_cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_down_counter.sv
// Loadable down-counter with a zero flag.
//   clk, rst  : clock, synchronous active-high reset (clears to 0)
//   load      : load load_val (has priority over dec)
//   load_val  : value to load
//   dec       : decrement by one; holds at zero
//   zero      : count == 0
module piso_down_counter
  import piso_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer feeding the SISO shift register si input.
//   clk, rst    : clock, synchronous active-high reset
//   in_data     : WIDTH-bit word, taken when in_valid & in_ready
//   in_valid    : in_data valid
//   in_ready    : combinational; IDLE, or last bit of a word when GAP_CYCLES==0
//   so          : registered serial data, IDLE_LEVEL when not sending
//   so_valid    : registered, so carries a data bit
//   sof         : registered, so carries the first bit of a word
//   busy        : state != IDLE
//   words_sent  : registered completed-word count, wraps at 2^16
//
// state | meaning
// IDLE  | waiting for a word, in_ready=1
// SHIFT | so shows one bit per cycle; bit counter holds bits still to come
// GAP   | idle gap of GAP_CYCLES cycles, in_ready=0
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             so,
  output logic             so_valid,
  output logic             sof,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam int BCW = bit_cnt_w(WIDTH);
  localparam bit NO_GAP = (GAP_CYCLES == 0);
  localparam logic [BCW-1:0] BIT_LOAD = BCW'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(NO_GAP ? 0 : GAP_CYCLES - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic             bit_load, bit_dec, bit_zero;
  logic             gap_load, gap_dec, gap_zero;
  logic             accept, last_bit;
  logic             first_bit;
  logic [WIDTH-1:0] sreg_load, sreg_shift;

  piso_down_counter #(.W(BCW)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (bit_load),
    .load_val (BIT_LOAD),
    .dec      (bit_dec),
    .zero     (bit_zero)
  );

  piso_down_counter #(.W(GAP_CNT_W)) u_gap_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  assign last_bit = (state == SHIFT) && bit_zero;
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = (state == IDLE) || (NO_GAP && last_bit);
    end
  end

  // The first bit goes straight to so on accept; sreg keeps the rest,
  // pre-shifted so the next bit always sits at the output end.
  assign first_bit  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign sreg_load  = MSB_FIRST ? {in_data[WIDTH-2:0], 1'b0} : {1'b0, in_data[WIDTH-1:1]};
  assign sreg_shift = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

  always_comb begin
    state_nx = state;
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          bit_load = 1'b1;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (!bit_zero) begin
          bit_dec = 1'b1;
        end else if (accept) begin
          bit_load = 1'b1;
        end else if (!NO_GAP) begin
          gap_load = 1'b1;
          state_nx = GAP;
        end else begin
          state_nx = IDLE;
        end
      end
      GAP: begin
        if (gap_zero) begin
          state_nx = IDLE;
        end else begin
          gap_dec = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sreg       <= '0;
      so         <= IDLE_LEVEL;
      so_valid   <= 1'b0;
      sof        <= 1'b0;
      words_sent <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        so       <= first_bit;
        so_valid <= 1'b1;
        sof      <= 1'b1;
        sreg     <= sreg_load;
      end else if ((state == SHIFT) && !bit_zero) begin
        so       <= MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        so_valid <= 1'b1;
        sof      <= 1'b0;
        sreg     <= sreg_shift;
      end else begin
        so       <= IDLE_LEVEL;
        so_valid <= 1'b0;
        sof      <= 1'b0;
      end
      if (last_bit) begin
        words_sent <= words_sent + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances sharing stimulus
//   u0: defaults (MSB first, no gap)
//   u1: LSB first, idle level 1
//   u2: MSB first, GAP_CYCLES=3
// A word-level reference model predicts every output of every instance each
// cycle; directed scenarios add fixed expected sequences on top.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] in_data = 4'h0;
  logic       in_valid = 1'b0;
  logic [2:0] in_ready_v, so_v, so_valid_v, sof_v, busy_v;
  logic [15:0] ws_v [3];

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .so(so_v[0]), .so_valid(so_valid_v[0]), .sof(sof_v[0]), .busy(busy_v[0]), .words_sent(ws_v[0]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP_CYCLES(0), .IDLE_LEVEL(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .so(so_v[1]), .so_valid(so_valid_v[1]), .sof(sof_v[1]), .busy(busy_v[1]), .words_sent(ws_v[1]));

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP_CYCLES(3), .IDLE_LEVEL(1'b0)) u2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .so(so_v[2]), .so_valid(so_valid_v[2]), .sof(sof_v[2]), .busy(busy_v[2]), .words_sent(ws_v[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per instance, the word in flight, the index of the bit
  // currently on so, the gap cycles still to serve and the word count.
  bit          m_msb [3] = '{1'b1, 1'b0, 1'b1};
  bit          m_idle[3] = '{1'b0, 1'b1, 1'b0};
  int          m_gap [3] = '{0, 0, 3};
  bit          snd   [3];
  int          k     [3];
  int          gl    [3];
  logic [3:0]  wd    [3];
  logic [15:0] cnt   [3];

  function automatic bit exp_ready(input int i);
    if (rst) return 1'b0;
    return (!snd[i] && gl[i] == 0) || (snd[i] && k[i] == 3 && m_gap[i] == 0);
  endfunction

  function automatic bit exp_so(input int i);
    if (!snd[i]) return m_idle[i];
    return wd[i][m_msb[i] ? 3 - k[i] : k[i]];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        snd[i] = 1'b0; k[i] = 0; gl[i] = 0; cnt[i] = 16'd0; wd[i] = 4'h0;
      end else begin
        bit acc;
        acc = in_valid && exp_ready(i);
        if (snd[i] && k[i] == 3) begin
          cnt[i] = cnt[i] + 16'd1;
          snd[i] = 1'b0;
          gl[i]  = m_gap[i];
        end else if (snd[i]) begin
          k[i] = k[i] + 1;
        end else if (gl[i] > 0) begin
          gl[i] = gl[i] - 1;
        end
        if (acc) begin
          wd[i] = in_data; snd[i] = 1'b1; k[i] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("m%0d_so", i), so_v[i], exp_so(i));
        check_eq($sformatf("m%0d_so_valid", i), so_valid_v[i], snd[i]);
        check_eq($sformatf("m%0d_sof", i), sof_v[i], snd[i] && k[i] == 0);
        check_eq($sformatf("m%0d_in_ready", i), in_ready_v[i], exp_ready(i));
        check_eq($sformatf("m%0d_busy", i), busy_v[i], snd[i] || gl[i] > 0);
        check_eq($sformatf("m%0d_words", i), ws_v[i], cnt[i]);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      cyc(); in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [3:0]  pat0, pat1;
    logic [7:0]  pat8;
    logic [15:0] ws_before;
    int dead, gated;

    // reset
    cyc(); chk_en = 1'b1;
    cyc(); #1;
    check_eq("rst_so", so_v[0], 1'b0);
    check_eq("rst_so_idle1", so_v[1], 1'b1);
    check_eq("rst_valid", so_valid_v[0], 1'b0);
    check_eq("rst_ready", in_ready_v[0], 1'b0);
    check_eq("rst_words", ws_v[0], 16'd0);
    cyc(); rst = 1'b0; #1;
    check_eq("post_rst_ready", in_ready_v[0], 1'b1);
    idle(2);

    // single word 1011, MSB first on u0 and LSB first on u1
    pat0 = 4'b1011; pat1 = 4'b1101;
    cyc(); in_data = 4'b1011; in_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      if (c == 1) in_valid = 1'b0;
      in_data = 4'($urandom);
      #1;
      if (c <= 4) begin
        check_eq("single_so", so_v[0], pat0[4-c]);
        check_eq("single_valid", so_valid_v[0], 1'b1);
        check_eq("single_sof", sof_v[0], c == 1);
        check_eq("lsb_so", so_v[1], pat1[4-c]);
      end else begin
        check_eq("single_end_so", so_v[0], 1'b0);
        check_eq("single_end_valid", so_valid_v[0], 1'b0);
        check_eq("single_words", ws_v[0], 16'd1);
        check_eq("lsb_end_idle", so_v[1], 1'b1);
      end
    end
    idle(8);

    // back-to-back A then 5 on u0
    pat8 = 8'b1010_0101;
    cyc(); in_data = 4'hA; in_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c == 1) in_data = 4'h5;
      if (c == 5) in_valid = 1'b0;
      #1;
      if (c <= 8) begin
        check_eq("b2b_so", so_v[0], pat8[8-c]);
        check_eq("b2b_valid", so_valid_v[0], 1'b1);
        check_eq("b2b_sof", sof_v[0], (c == 1) || (c == 5));
      end else begin
        check_eq("b2b_words", ws_v[0], 16'd3);
        check_eq("b2b_end_valid", so_valid_v[0], 1'b0);
      end
    end
    idle(8);

    // gap of 3 on u2: 9 then 6
    dead = 0; gated = 0;
    cyc(); in_data = 4'h9; in_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      cyc();
      if (c == 1) in_data = 4'h6;
      if (c == 9) in_valid = 1'b0;
      #1;
      if (c >= 5 && c <= 8) begin
        if (!so_valid_v[2]) dead++;
        if (!so_valid_v[2] && !in_ready_v[2]) gated++;
      end
      if (c == 4) check_eq("gap_last_bit", so_v[2], 1'b1);
      if (c == 9) begin
        check_eq("gap_second_sof", sof_v[2], 1'b1);
        check_eq("gap_second_so", so_v[2], 1'b0);
      end
    end
    check_eq("gap_dead_cycles", dead, 4);
    check_eq("gap_gated_cycles", gated, 3);
    idle(10);

    // busy ignore: F pulsed while 0 shifts out of u0
    ws_before = cnt[0];
    cyc(); in_data = 4'h0; in_valid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      case (c)
        1: in_valid = 1'b0;
        2: begin in_data = 4'hF; in_valid = 1'b1; end
        3: begin in_valid = 1'b0; in_data = 4'h0; end
        default: ;
      endcase
      #1;
      if (c <= 4) begin
        check_eq("ignore_so", so_v[0], 1'b0);
        check_eq("ignore_valid", so_valid_v[0], 1'b1);
      end else begin
        check_eq("ignore_words", ws_v[0], ws_before + 16'd1);
      end
    end
    idle(8);

    // reset after two bits of C
    cyc(); in_data = 4'hC; in_valid = 1'b1;
    cyc(); in_valid = 1'b0; #1;
    check_eq("rstmid_bit1", so_v[0], 1'b1);
    cyc(); rst = 1'b1; #1;
    check_eq("rstmid_bit2", so_v[0], 1'b1);
    check_eq("rstmid_ready_in_rst", in_ready_v[0], 1'b0);
    cyc(); #1;
    check_eq("rstmid_so", so_v[0], 1'b0);
    check_eq("rstmid_valid", so_valid_v[0], 1'b0);
    check_eq("rstmid_words", ws_v[0], 16'd0);
    check_eq("rstmid_busy", busy_v[0], 1'b0);
    check_eq("rstmid_ready_held", in_ready_v[0], 1'b0);
    cyc(); rst = 1'b0; #1;
    check_eq("rstmid_ready_release", in_ready_v[0], 1'b1);

    // randomized traffic, occasional reset
    for (int c = 0; c < 600; c++) begin
      cyc();
      rst      = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 9) < 6);
      in_data  = 4'($urandom);
    end
    cyc(); rst = 1'b0; in_valid = 1'b0;
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
